spi_flash_arbiter: RTL and testbench

Shares the single W25Q32 SPI flash port between two requesters. Port 0 is the bubble page loader: it has fixed priority and hard real-time deadlines. Port 1 is a secondary reader, such as the image-select/config fetch or a future bootloader/updater. The block sits between the requesters and the nROMCS/ROMMOSI/ROMCLK/ROMMISO pins; it enforces nCS deselect guard time and watchdog timeouts on stuck owners.

---
 rtl/spi_flash_arbiter_if.sv | 23 ++
 rtl/spi_flash_arbiter.sv | 166 ++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_arbiter_if.sv
// Signal bundle between the two flash requesters, the flash pins and
// spi_flash_arbiter. The arbiter uses the slave modport; the requester/flash
// side uses master. MISO is driven by the flash and read by both requesters
// directly, so the arbiter never touches it.
interface spi_flash_arbiter_if;
  logic REQ0, GNT0, nCS0, MOSI0, CLK0;
  logic REQ1, GNT1, nCS1, MOSI1, CLK1;
  logic nCS, MOSI, CLK, MISO;
  logic BUSY, TOERR, TOSRC;

  modport slave (
    input  REQ0, nCS0, MOSI0, CLK0,
    input  REQ1, nCS1, MOSI1, CLK1,
    output GNT0, GNT1, nCS, MOSI, CLK, BUSY, TOERR, TOSRC
  );

  modport master (
    output REQ0, nCS0, MOSI0, CLK0,
    output REQ1, nCS1, MOSI1, CLK1,
    output MISO,
    input  GNT0, GNT1, nCS, MOSI, CLK, BUSY, TOERR, TOSRC
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Two-port arbiter for the shared W25Q32 SPI flash pins. Port 0 (bubble page
// loader) has fixed priority; port 1 is a secondary reader. Enforces a nCS
// deselect guard between ownerships and a watchdog on stuck owners.
// Optional macro STARVE_GUARD_EN: promotes port 1 after MAX_WAIT waiting
// cycles so it cannot starve behind back-to-back port-0 traffic.
module spi_flash_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 49152
`ifdef STARVE_GUARD_EN
  ,
  parameter int unsigned MAX_WAIT       = 4096
`endif
) (
  input  logic                  MCLK,
  input  logic                  nRESET,
  spi_flash_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} state_t;

  localparam int unsigned GW      = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  state_t          w_pick;
  logic [GW-1:0]   r_guard_cnt;
  logic [15:0]     r_wd_cnt;
  logic            r_mask0, r_mask1;
  logic            r_toerr, r_tosrc;
  logic            w_timeout;
  logic            w_promote;

`ifdef STARVE_GUARD_EN
  localparam logic [12:0] WAIT_MAX = 13'(MAX_WAIT);
  logic [12:0] r_wait;

  // Port-1 starvation counter: saturates at WAIT_MAX, which promotes port 1.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET)
      r_wait <= '0;
    else if (!bus.REQ1 || bus.GNT1)
      r_wait <= '0;
    else if (!r_mask1 && r_wait != WAIT_MAX)
      r_wait <= r_wait + 13'd1;
  end

  assign w_promote = (r_wait == WAIT_MAX);
`else
  assign w_promote = 1'b0;
`endif

  // Arbitration decision, taken in IDLE and on the last GUARD cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_pick = IDLE;
    if (w_promote && bus.REQ1 && !r_mask1)
      w_pick = OWN1;
    else if (bus.REQ0 && !r_mask0)
      w_pick = OWN0;
    else if (bus.REQ1 && !r_mask1)
      w_pick = OWN1;
  end

  // Next-state logic: release has precedence over watchdog expiry.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE:  w_next = w_pick;
      OWN0: begin
        if (!bus.REQ0) begin
          w_next = GUARD;
        end else if (r_wd_cnt == TO_LAST) begin
          w_next    = GUARD;
          w_timeout = 1'b1;
        end
      end
      OWN1: begin
        if (!bus.REQ1) begin
          w_next = GUARD;
        end else if (r_wd_cnt == TO_LAST) begin
          w_next    = GUARD;
          w_timeout = 1'b1;
        end
      end
      GUARD: if (r_guard_cnt == '0) w_next = w_pick;
      default: w_next = IDLE;
    endcase
  end

  // State register; async reset drops ownership and deselects nCS at once.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Guard down-counter (loaded on GUARD entry) and per-grant watchdog.
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_guard_cnt <= '0;
      r_wd_cnt    <= '0;
    end else begin
      if (r_state != GUARD && w_next == GUARD)
        r_guard_cnt <= GW'(GUARD_CYCLES);
      else if (r_state == GUARD && r_guard_cnt != '0)
        r_guard_cnt <= r_guard_cnt - 1'b1;

      if ((w_next == OWN0 || w_next == OWN1) && w_next != r_state)
        r_wd_cnt <= '0;
      else if (r_state == OWN0 || r_state == OWN1)
        r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  // Timeout reporting and re-grant masks (cleared once REQx is seen low).
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_toerr <= 1'b0;
      r_tosrc <= 1'b0;
      r_mask0 <= 1'b0;
      r_mask1 <= 1'b0;
    end else begin
      r_toerr <= w_timeout;
      if (w_timeout)
        r_tosrc <= (r_state == OWN1);

      if (w_timeout && r_state == OWN0) r_mask0 <= 1'b1;
      else if (!bus.REQ0)               r_mask0 <= 1'b0;

      if (w_timeout && r_state == OWN1) r_mask1 <= 1'b1;
      else if (!bus.REQ1)               r_mask1 <= 1'b0;
    end
  end

  // Pin mux from the registered owner; idle pins when nobody owns the bus.
  always_comb begin
    bus.nCS  = 1'b1;
    bus.MOSI = 1'b0;
    bus.CLK  = 1'b0;
    case (r_state)
      OWN0: begin
        bus.nCS  = bus.nCS0;
        bus.MOSI = bus.MOSI0;
        bus.CLK  = bus.CLK0;
      end
      OWN1: begin
        bus.nCS  = bus.nCS1;
        bus.MOSI = bus.MOSI1;
        bus.CLK  = bus.CLK1;
      end
      default: ;
    endcase
  end

  assign bus.GNT0  = (r_state == OWN0);
  assign bus.GNT1  = (r_state == OWN1);
  assign bus.BUSY  = (r_state != IDLE);
  assign bus.TOERR = r_toerr;
  assign bus.TOSRC = r_tosrc;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Self-checking bench for spi_flash_arbiter. Expected grant and timeout
// events are queued as stimulus is driven; a monitor pops and compares them
// when the DUT raises a grant or TOERR.
module tb_spi_flash_arbiter;
  localparam int G  = 4;
  localparam int TO = 64;
`ifdef STARVE_GUARD_EN
  localparam int MW = 16;
`endif

  logic MCLK = 1'b0;
  logic nRESET;

  spi_flash_arbiter_if bus();

  spi_flash_arbiter #(
    .GUARD_CYCLES(G),
    .TIMEOUT_CYCLES(TO)
`ifdef STARVE_GUARD_EN
    ,
    .MAX_WAIT(MW)
`endif
  ) dut (
    .MCLK(MCLK),
    .nRESET(nRESET),
    .bus(bus)
  );

  always #5 MCLK = ~MCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge MCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int port;
    int cyc;
  } ev_t;

  ev_t gnt_q[$];
  ev_t to_q[$];

  logic p_gnt0 = 1'b0;
  logic p_gnt1 = 1'b0;

  task automatic grant_seen(input int port);
    ev_t e;
    if (gnt_q.size() == 0) begin
      check("gnt_unexpected_port", port, 99);
    end else begin
      e = gnt_q.pop_front();
      check("gnt_port", port, e.port);
      check("gnt_cycle", cyc, e.cyc);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge MCLK) begin
    if (nRESET) begin
      if (bus.GNT0 || bus.GNT1)
        check("gnt_exclusive", bus.GNT0 & bus.GNT1, 0);
      if (bus.GNT0 && !p_gnt0) grant_seen(0);
      if (bus.GNT1 && !p_gnt1) grant_seen(1);
      if (bus.TOERR) begin
        if (to_q.size() == 0) begin
          check("toerr_unexpected", bus.TOERR, 0);
        end else begin
          ev_t e;
          e = to_q.pop_front();
          check("tosrc", bus.TOSRC, e.port);
          check("toerr_cycle", cyc, e.cyc);
        end
      end
    end
    p_gnt0 <= bus.GNT0;
    p_gnt1 <= bus.GNT1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  int n, m, p, g, e;
  bit p1;

  initial begin
    bus.REQ0 = 0; bus.nCS0 = 1; bus.MOSI0 = 0; bus.CLK0 = 0;
    bus.REQ1 = 0; bus.nCS1 = 1; bus.MOSI1 = 0; bus.CLK1 = 0;
    bus.MISO = 0;
    nRESET = 0;

    // Reset values
    @(negedge MCLK);
    @(negedge MCLK);
    check("rst_gnt0", bus.GNT0, 0);
    check("rst_gnt1", bus.GNT1, 0);
    check("rst_ncs", bus.nCS, 1);
    check("rst_mosi", bus.MOSI, 0);
    check("rst_clk", bus.CLK, 0);
    check("rst_busy", bus.BUSY, 0);
    check("rst_toerr", bus.TOERR, 0);
    check("rst_tosrc", bus.TOSRC, 0);
    tick(1);
    nRESET = 1;
    tick(2);

    // 1: port 0 alone, pins follow port 0, then a G+1 cycle guard
    n = cyc;
    bus.REQ0 = 1;
    gnt_q.push_back('{0, n + 1});
    tick(1);
    for (int i = 0; i < 20; i++) begin
      bus.nCS0  = (i % 3 == 0);
      bus.MOSI0 = i[0];
      bus.CLK0  = i[1];
      @(negedge MCLK);
      check("own0_ncs", bus.nCS, (i % 3 == 0));
      check("own0_mosi", bus.MOSI, i[0]);
      check("own0_clk", bus.CLK, i[1]);
      tick(1);
    end
    bus.REQ0 = 0;
    bus.nCS0 = 0; bus.MOSI0 = 1; bus.CLK0 = 1;
    tick(1);
    for (int k = 0; k <= G; k++) begin
      @(negedge MCLK);
      check("guard_ncs", bus.nCS, 1);
      check("guard_mosi", bus.MOSI, 0);
      check("guard_clk", bus.CLK, 0);
      check("guard_busy", bus.BUSY, 1);
      check("guard_gnt0", bus.GNT0, 0);
      tick(1);
    end
    @(negedge MCLK);
    check("idle_busy", bus.BUSY, 0);
    check("idle_ncs", bus.nCS, 1);
    bus.nCS0 = 1; bus.MOSI0 = 0; bus.CLK0 = 0;
    tick(1);

    // 2: simultaneous requests, port 0 first, port 1 G+2 cycles after release
    n = cyc;
    bus.REQ0 = 1; bus.REQ1 = 1;
    gnt_q.push_back('{0, n + 1});
    tick(6);
    m = cyc;
    bus.REQ0 = 0;
    gnt_q.push_back('{1, m + G + 2});
    tick(G + 2 + 3);
    bus.REQ1 = 0;
    tick(G + 3);

    // 3: no preemption of an active port-1 grant
    n = cyc;
    bus.REQ1 = 1;
    gnt_q.push_back('{1, n + 1});
    tick(3);
    bus.REQ0 = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge MCLK);
      check("nopreempt_gnt1", bus.GNT1, 1);
      check("nopreempt_gnt0", bus.GNT0, 0);
      tick(1);
    end
    m = cyc;
    bus.REQ1 = 0;
    gnt_q.push_back('{0, m + G + 2});
    tick(G + 2 + 3);
    bus.REQ0 = 0;
    tick(G + 3);

    // 4: port-1 watchdog, mask until REQ1 pulses low, port 0 served meanwhile
    n = cyc;
    bus.REQ1 = 1;
    gnt_q.push_back('{1, n + 1});
    to_q.push_back('{1, n + TO + 1});
    tick(TO + 1);
    @(negedge MCLK);
    check("to1_gnt1_low", bus.GNT1, 0);
    tick(1);
    bus.REQ0 = 1;
    gnt_q.push_back('{0, n + TO + G + 2});
    tick(5);
    bus.REQ0 = 0;
    tick(G + 2 + 8);
    @(negedge MCLK);
    check("masked_gnt1", bus.GNT1, 0);
    check("masked_busy", bus.BUSY, 0);
    tick(1);
    p = cyc;
    bus.REQ1 = 0;
    tick(1);
    bus.REQ1 = 1;
    gnt_q.push_back('{1, p + 2});
    tick(3);
    @(negedge MCLK);
    check("tosrc_hold", bus.TOSRC, 1);
    tick(1);
    bus.REQ1 = 0;
    tick(G + 3);

    // 4b: port-0 watchdog reports TOSRC=0
    n = cyc;
    bus.REQ0 = 1;
    gnt_q.push_back('{0, n + 1});
    to_q.push_back('{0, n + TO + 1});
    tick(TO + 1);
    bus.REQ0 = 0;
    tick(G + 3);

    // 4c: release in the expiry cycle is a normal release (no TOERR, no mask)
    n = cyc;
    bus.REQ1 = 1;
    gnt_q.push_back('{1, n + 1});
    tick(TO);
    bus.REQ1 = 0;
    @(negedge MCLK);
    @(negedge MCLK);
    check("simul_gnt1", bus.GNT1, 0);
    check("simul_toerr", bus.TOERR, 0);
    check("simul_tosrc", bus.TOSRC, 0);
    tick(1);
    bus.REQ1 = 1;
    gnt_q.push_back('{1, n + TO + G + 2});
    tick(6);
    bus.REQ1 = 0;
    tick(G + 3);

    // 5: asynchronous reset in the middle of a port-0 ownership
    n = cyc;
    bus.REQ0 = 1; bus.nCS0 = 0;
    gnt_q.push_back('{0, n + 1});
    tick(3);
    @(negedge MCLK);
    check("pre_rst_ncs", bus.nCS, 0);
    #2;
    nRESET = 0;
    #1;
    check("async_rst_ncs", bus.nCS, 1);
    check("async_rst_gnt0", bus.GNT0, 0);
    check("async_rst_busy", bus.BUSY, 0);
    bus.REQ0 = 0; bus.nCS0 = 1;
    tick(2);
    nRESET = 1;
    tick(1);
    @(negedge MCLK);
    check("post_rst_busy", bus.BUSY, 0);
    check("post_rst_gnt0", bus.GNT0, 0);
    tick(1);
    n = cyc;
    bus.REQ0 = 1;
    gnt_q.push_back('{0, n + 1});
    tick(3);
    bus.REQ0 = 0;
    tick(G + 3);

`ifdef STARVE_GUARD_EN
    // 6: back-to-back port-0 traffic, port 1 promoted after MW waiting cycles
    n = cyc;
    bus.REQ0 = 1; bus.REQ1 = 1;
    g = n + 1;
    gnt_q.push_back('{0, g});
    tick(1);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      bus.REQ0 = 0;
      tick(2);
      bus.REQ0 = 1;
      e  = g + G + 3;
      p1 = ((e - 1 - n) >= MW);
      gnt_q.push_back('{p1 ? 1 : 0, e});
      tick(e - cyc);
      g = e;
      if (p1) break;
    end
    @(negedge MCLK);
    check("starve_gnt1", bus.GNT1, 1);
    check("starve_req0_pending", bus.GNT0, 0);
    tick(3);
    m = cyc;
    bus.REQ1 = 0;
    gnt_q.push_back('{0, m + G + 2});
    tick(G + 5);
    bus.REQ0 = 0;
    tick(G + 3);
`endif

    check("gnt_q_left", gnt_q.size(), 0);
    check("to_q_left", to_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
